// File: rtl/tester_common_pkg.sv
// Shared types and constants for the traffic tester: port configuration,
// frame-checker statistics bundle, header constants and byte offsets.
package tester_common;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;

    localparam logic [15:0] OFF_ETH_TYPE = 16'd12;
    localparam logic [15:0] OFF_VER_IHL  = 16'd14;
    localparam logic [15:0] OFF_SRC_IP   = 16'd26;
    localparam logic [15:0] OFF_DST_IP   = 16'd30;

    typedef struct packed {
        logic [15:0] frame_size;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } port_config_t;

    typedef struct packed {
        logic [31:0] good_frames;
        logic [31:0] bad_frames;
        logic [63:0] good_bytes;
        logic [31:0] seq_errors;
    } frame_check_stats_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX_HDR,
        ST_SKIP,
        ST_STOPPING
    } check_state_t;

    // Byte idx of a 32-bit word in wire order (idx 0 is the MSB byte).
    function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/frame_checker.sv
// Receive-side frame checker: parses Ethernet/IPv4 headers and a sequence number
// byte by byte, classifies each frame as good or bad and keeps per-port statistics.
module frame_checker
    import tester_common::*;
#(
    parameter int unsigned SEQ_OFFSET = 34,
    parameter int unsigned MIN_FRAME  = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  port_config_t port_config,
    input  logic [47:0]  rx_mac,
    input  logic [7:0]   axis_s_data,
    input  logic         axis_s_valid,
    input  logic         axis_s_last,
    input  logic         axis_s_user,
    output logic         axis_s_ready,
    output logic         running,
    output logic [31:0]  good_frames,
    output logic [31:0]  bad_frames,
    output logic [63:0]  good_bytes,
    output logic [31:0]  seq_errors
);

    localparam logic [15:0] SEQ_OFF = 16'(SEQ_OFFSET);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

    check_state_t       state_q, state_d;
    logic               ready_q;
    logic               stopPend_q, stopPend_d;
    logic [15:0]        byteCnt_q, byteCnt_d;
    logic               mismatch_q, mismatch_d;
    logic [31:0]        rxSeq_q, rxSeq_d;
    logic [31:0]        expSeq_q, expSeq_d;
    frame_check_stats_t stats_q, stats_d;

    logic        beat, lastBeat, checkedLast;
    logic        checkEn, inSeq, mismatchNow, frameGood;
    logic [7:0]  expByte;
    logic [15:0] frameLen;
    logic [31:0] rxSeqNow;

    assign beat        = axis_s_valid & ready_q;
    assign lastBeat    = beat & axis_s_last;
    assign checkedLast = lastBeat & ((state_q == ST_RX_HDR) | (state_q == ST_STOPPING));

    assign axis_s_ready = ready_q;
    assign running      = (state_q != ST_IDLE);
    assign good_frames  = stats_q.good_frames;
    assign bad_frames   = stats_q.bad_frames;
    assign good_bytes   = stats_q.good_bytes;
    assign seq_errors   = stats_q.seq_errors;

    // Expected value of the header byte at the current offset, if that offset is checked.
    always_comb begin
        checkEn = 1'b0;
        expByte = 8'h00;
        case (byteCnt_q)
            16'd0:                 begin checkEn = 1'b1; expByte = rx_mac[47:40]; end
            16'd1:                 begin checkEn = 1'b1; expByte = rx_mac[39:32]; end
            16'd2:                 begin checkEn = 1'b1; expByte = rx_mac[31:24]; end
            16'd3:                 begin checkEn = 1'b1; expByte = rx_mac[23:16]; end
            16'd4:                 begin checkEn = 1'b1; expByte = rx_mac[15:8];  end
            16'd5:                 begin checkEn = 1'b1; expByte = rx_mac[7:0];   end
            OFF_ETH_TYPE:          begin checkEn = 1'b1; expByte = ETH_TYPE_IPV4[15:8]; end
            OFF_ETH_TYPE + 16'd1:  begin checkEn = 1'b1; expByte = ETH_TYPE_IPV4[7:0];  end
            OFF_VER_IHL:           begin checkEn = 1'b1; expByte = IPV4_VER_IHL; end
            default:               ;
        endcase
        if (byteCnt_q >= OFF_SRC_IP && byteCnt_q < OFF_SRC_IP + 16'd4) begin
            checkEn = 1'b1;
            expByte = wordByte(port_config.src_ip, 2'(byteCnt_q - OFF_SRC_IP));
        end
        if (byteCnt_q >= OFF_DST_IP && byteCnt_q < OFF_DST_IP + 16'd4) begin
            checkEn = 1'b1;
            expByte = wordByte(port_config.dst_ip, 2'(byteCnt_q - OFF_DST_IP));
        end
    end

    // Per-beat parser; the current beat is folded in so the last beat is classified directly.
    always_comb begin
        inSeq       = (byteCnt_q >= SEQ_OFF) && (byteCnt_q < SEQ_OFF + 16'd4);
        frameLen    = (byteCnt_q == 16'hFFFF) ? 16'hFFFF : byteCnt_q + 16'd1;
        mismatchNow = mismatch_q | (beat & checkEn & (axis_s_data != expByte));
        rxSeqNow    = (beat && inSeq) ? {rxSeq_q[23:0], axis_s_data} : rxSeq_q;
        frameGood   = (frameLen == port_config.frame_size) && (frameLen >= MIN_LEN) &&
                      !mismatchNow && !axis_s_user;

        byteCnt_d  = byteCnt_q;
        mismatch_d = mismatchNow;
        rxSeq_d    = rxSeqNow;
        if (beat) begin
            byteCnt_d = axis_s_last ? 16'd0 : frameLen;
        end
        if (lastBeat) begin
            mismatch_d = 1'b0;
            rxSeq_d    = 32'd0;
        end
    end

    always_comb begin
        stats_d  = stats_q;
        expSeq_d = expSeq_q;
        if (start) begin
            stats_d  = '0;
            expSeq_d = 32'd0;
        end else if (checkedLast) begin
            if (frameGood) begin
                stats_d.good_frames = stats_q.good_frames + 32'd1;
                stats_d.good_bytes  = stats_q.good_bytes + 64'(frameLen);
                if (rxSeqNow != expSeq_q) begin
                    stats_d.seq_errors = stats_q.seq_errors + 32'd1;
                end
                expSeq_d = rxSeqNow + 32'd1;
            end else begin
                stats_d.bad_frames = stats_q.bad_frames + 32'd1;
            end
        end
    end

    // A frame is in progress whenever the byte counter will be non-zero after this cycle.
    always_comb begin
        state_d    = state_q;
        stopPend_d = stopPend_q;
        if (start) begin
            state_d    = (byteCnt_d != 16'd0) ? ST_SKIP : ST_RX_HDR;
            stopPend_d = 1'b0;
        end else begin
            case (state_q)
                ST_RX_HDR: begin
                    if (stop) begin
                        state_d = (byteCnt_d != 16'd0) ? ST_STOPPING : ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (lastBeat) begin
                        state_d    = (stop || stopPend_q) ? ST_IDLE : ST_RX_HDR;
                        stopPend_d = 1'b0;
                    end else if (stop) begin
                        stopPend_d = 1'b1;
                    end
                end
                ST_STOPPING: begin
                    if (lastBeat) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            stopPend_q <= 1'b0;
            byteCnt_q  <= 16'd0;
            mismatch_q <= 1'b0;
            rxSeq_q    <= 32'd0;
            expSeq_q   <= 32'd0;
            stats_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            stopPend_q <= stopPend_d;
            byteCnt_q  <= byteCnt_d;
            mismatch_q <= mismatch_d;
            rxSeq_q    <= rxSeq_d;
            expSeq_q   <= expSeq_d;
            stats_q    <= stats_d;
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// Scoreboard bench for frame_checker: a frame-level reference model queues the expected
// statistics after every counted frame, and a monitor compares them when the counters move.
module tb_frame_checker;
    import tester_common::*;

    typedef logic [7:0] byteQ_t[$];
    typedef struct packed {
        frame_check_stats_t s;
        int                 cyc;
    } expItem_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    port_config_t cfg;
    logic [47:0]  rxMac;
    logic [7:0]   data = 8'h00;
    logic         valid = 1'b0;
    logic         last = 1'b0;
    logic         user = 1'b0;
    logic         ready;
    logic         running;
    logic [31:0]  goodFrames;
    logic [31:0]  badFrames;
    logic [63:0]  goodBytes;
    logic [31:0]  seqErrors;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    frame_check_stats_t mStats;
    logic [31:0]        mExpSeq;
    bit                 mChecking;
    expItem_t           expQ[$];

    frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .port_config  (cfg),
        .rx_mac       (rxMac),
        .axis_s_data  (data),
        .axis_s_valid (valid),
        .axis_s_last  (last),
        .axis_s_user  (user),
        .axis_s_ready (ready),
        .running      (running),
        .good_frames  (goodFrames),
        .bad_frames   (badFrames),
        .good_bytes   (goodBytes),
        .seq_errors   (seqErrors)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit l, input bit u, input bit s, input bit p);
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        last  = l;
        user  = u;
        start = s;
        stop  = p;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        data  = 8'($urandom);
        valid = 1'b0;
        last  = 1'b0;
        user  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Called at the negedge where the triggering input is driven; the DUT reacts one edge later.
    task automatic pushExpected();
        expItem_t e;
        e.s   = mStats;
        e.cyc = cyc + 1;
        expQ.push_back(e);
    endtask

    task automatic modelStart();
        bit wasNonZero;
        wasNonZero = (mStats != '0);
        mStats     = '0;
        mExpSeq    = 32'd0;
        mChecking  = 1'b1;
        if (wasNonZero) pushExpected();
    endtask

    function automatic bit frameIsGood(input byteQ_t f, input bit u);
        int n;
        n = f.size();
        if (u || n < 38 || n != int'(cfg.frame_size)) return 1'b0;
        if ({f[0], f[1], f[2], f[3], f[4], f[5]} != rxMac) return 1'b0;
        if ({f[12], f[13]} != 16'h0800 || f[14] != 8'h45) return 1'b0;
        if ({f[26], f[27], f[28], f[29]} != cfg.src_ip) return 1'b0;
        if ({f[30], f[31], f[32], f[33]} != cfg.dst_ip) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelFrameDone(input byteQ_t f, input bit u);
        logic [31:0] seq;
        if (frameIsGood(f, u)) begin
            seq = {f[34], f[35], f[36], f[37]};
            mStats.good_frames = mStats.good_frames + 32'd1;
            mStats.good_bytes  = mStats.good_bytes + 64'(f.size());
            if (seq != mExpSeq) mStats.seq_errors = mStats.seq_errors + 32'd1;
            mExpSeq = seq + 32'd1;
        end else begin
            mStats.bad_frames = mStats.bad_frames + 32'd1;
        end
        pushExpected();
    endtask

    task automatic buildFrame(input int len, input logic [31:0] seq, output byteQ_t f);
        logic [47:0] m;
        logic [31:0] w;
        f = {};
        for (int i = 0; i < ((len > 38) ? len : 38); i++) f.push_back(8'($urandom));
        m = rxMac;
        for (int i = 0; i < 6; i++) begin f[i] = m[47:40]; m = m << 8; end
        f[12] = 8'h08;
        f[13] = 8'h00;
        f[14] = 8'h45;
        w = cfg.src_ip;
        for (int i = 0; i < 4; i++) begin f[26 + i] = w[31:24]; w = w << 8; end
        w = cfg.dst_ip;
        for (int i = 0; i < 4; i++) begin f[30 + i] = w[31:24]; w = w << 8; end
        w = seq;
        for (int i = 0; i < 4; i++) begin f[34 + i] = w[31:24]; w = w << 8; end
        while (f.size() > len) void'(f.pop_back());
    endtask

    task automatic sendFrame(input byteQ_t f, input bit userErr, input int startAt,
                             input int stopAt, input int maxGap);
        bit skipped;
        bit stopAfter;
        bit isLast;
        int gap;
        skipped   = 1'b0;
        stopAfter = 1'b0;
        for (int i = 0; i < f.size(); i++) begin
            gap = (maxGap > 0 && i > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            repeat (gap) idleCycle();
            isLast = (i == f.size() - 1);
            applyStimulus(f[i], isLast, isLast ? userErr : 1'($urandom), i == startAt, i == stopAt);
            if (i == startAt) begin modelStart(); skipped = 1'b1; end
            if (i == stopAt) stopAfter = 1'b1;
            if (isLast && mChecking && !skipped) begin
                modelFrameDone(f, userErr);
                if (stopAfter) mChecking = 1'b0;
            end
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        valid = 1'b0; last = 1'b0; start = 1'b1; stop = 1'b0;
        modelStart();
        idleCycle();
    endtask

    task automatic pulseStop();
        @(negedge clk);
        valid = 1'b0; last = 1'b0; start = 1'b0; stop = 1'b1;
        mChecking = 1'b0;
        idleCycle();
    endtask

    // Pops one expected snapshot whenever the DUT statistics change.
    task automatic monitorLoop();
        frame_check_stats_t lastSeen, cur;
        expItem_t e;
        lastSeen = '0;
        forever begin
            @(negedge clk);
            cur.good_frames = goodFrames;
            cur.bad_frames  = badFrames;
            cur.good_bytes  = goodBytes;
            cur.seq_errors  = seqErrors;
            if (rst) begin
                lastSeen = '0;
            end else if (cur != lastSeen) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_update: got good=%0d bad=%0d bytes=%0d seqerr=%0d, expected no change",
                             cur.good_frames, cur.bad_frames, cur.good_bytes, cur.seq_errors);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_good_frames", 64'(cur.good_frames), 64'(e.s.good_frames));
                    checkOutput("sb_bad_frames",  64'(cur.bad_frames),  64'(e.s.bad_frames));
                    checkOutput("sb_good_bytes",  cur.good_bytes,       e.s.good_bytes);
                    checkOutput("sb_seq_errors",  64'(cur.seq_errors),  64'(e.s.seq_errors));
                    checkOutput("sb_update_cycle", 64'(cyc), 64'(e.cyc));
                end
                lastSeen = cur;
            end
        end
    endtask

    initial begin
        byteQ_t f;
        int     hdrIdx[17] = '{0, 1, 2, 3, 4, 5, 12, 13, 14, 26, 27, 28, 29, 30, 31, 32, 33};
        int     kind, len, idx;
        bit     u;
        logic [31:0] seq;

        mStats    = '0;
        mExpSeq   = 32'd0;
        mChecking = 1'b0;
        rxMac          = {16'($urandom), 32'($urandom)};
        cfg.src_ip     = $urandom;
        cfg.dst_ip     = $urandom;
        cfg.frame_size = 16'd100;

        fork monitorLoop(); join_none

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_running", 64'(running), 64'd0);
        checkOutput("reset_good_frames", 64'(goodFrames), 64'd0);
        checkOutput("reset_good_bytes", goodBytes, 64'd0);
        rst = 1'b0;
        idleCycle();
        checkOutput("ready_after_reset", 64'(ready), 64'd1);

        // A frame arriving while idle is ignored.
        buildFrame(100, 32'd0, f);
        sendFrame(f, 1'b0, -1, -1, 0);
        idleCycle();

        pulseStart();
        checkOutput("running_after_start", 64'(running), 64'd1);

        buildFrame(100, 32'd0, f);
        sendFrame(f, 1'b0, -1, -1, 0);
        checkOutput("good_frames_before_edge", 64'(goodFrames), 64'd0);
        idleCycle();
        checkOutput("good_frames_first", 64'(goodFrames), 64'd1);
        checkOutput("good_bytes_first", goodBytes, 64'd100);

        pulseStart();
        buildFrame(100, 32'd0, f);
        f[33] = f[33] ^ 8'h10;
        sendFrame(f, 1'b0, -1, -1, 1);
        buildFrame(99, 32'd0, f);
        sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd0, f);
        sendFrame(f, 1'b1, -1, -1, 0);
        buildFrame(100, 32'd0, f);
        sendFrame(f, 1'b0, -1, -1, 0);
        idleCycle();
        checkOutput("bad_frames_three", 64'(badFrames), 64'd3);
        checkOutput("seq_errors_after_bad", 64'(seqErrors), 64'd0);

        pulseStart();
        buildFrame(100, 32'd0, f); sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd1, f); sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd3, f); sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd4, f); sendFrame(f, 1'b0, -1, -1, 0);
        idleCycle();
        checkOutput("b2b_good_frames", 64'(goodFrames), 64'd4);
        checkOutput("b2b_good_bytes", goodBytes, 64'd400);
        checkOutput("b2b_seq_errors", 64'(seqErrors), 64'd1);

        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(9, 0));
            len  = 100;
            u    = 1'b0;
            seq  = ($urandom_range(3, 0) == 0) ? 32'($urandom) : mExpSeq;
            if (kind == 6) len = ($urandom_range(1, 0) == 0) ? 99 : 101;
            if (kind == 8) len = 1;
            if (kind == 9) len = 37;
            if (kind == 7) u = 1'b1;
            buildFrame(len, seq, f);
            if (kind == 4 || kind == 5) begin
                idx = hdrIdx[$urandom_range(16, 0)];
                f[idx] = f[idx] ^ (8'h01 << $urandom_range(7, 0));
            end
            sendFrame(f, u, -1, -1, (kind % 2 == 0) ? 2 : 0);
        end
        idleCycle();

        // Minimum-length boundary and sequence-number wrap.
        pulseStop();
        checkOutput("running_after_stop", 64'(running), 64'd0);
        cfg.frame_size = 16'd37;
        pulseStart();
        buildFrame(37, 32'd0, f); sendFrame(f, 1'b0, -1, -1, 0);
        idleCycle();
        pulseStop();
        cfg.frame_size = 16'd38;
        pulseStart();
        buildFrame(38, 32'd0, f);          sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(38, 32'hFFFF_FFFF, f);  sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(38, 32'd0, f);          sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(38, mExpSeq, f);        sendFrame(f, 1'b1, -1, -1, 0);
        idleCycle();
        checkOutput("wrap_seq_errors", 64'(seqErrors), 64'd1);
        pulseStop();
        cfg.frame_size = 16'd100;
        pulseStart();

        // Start mid-frame: that frame is skipped, the next one is checked.
        buildFrame(100, 32'd7, f); sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd8, f); sendFrame(f, 1'b0, 50, -1, 0);
        buildFrame(100, 32'd0, f); sendFrame(f, 1'b0, -1, -1, 0);
        idleCycle();
        checkOutput("skip_good_frames", 64'(goodFrames), 64'd1);

        // Stop mid-frame: frame still counted, running falls after its last beat.
        buildFrame(100, mExpSeq, f);
        sendFrame(f, 1'b0, -1, 40, 0);
        checkOutput("running_at_last_beat", 64'(running), 64'd1);
        idleCycle();
        checkOutput("running_after_stopped_frame", 64'(running), 64'd0);
        checkOutput("stop_good_frames", 64'(goodFrames), 64'd2);
        buildFrame(100, mExpSeq, f);
        sendFrame(f, 1'b0, -1, -1, 0);
        repeat (3) idleCycle();

        // Reset in the middle of a frame with non-zero counters.
        pulseStart();
        buildFrame(100, 32'd0, f); sendFrame(f, 1'b0, -1, -1, 0);
        buildFrame(100, 32'd1, f);
        for (int i = 0; i < 20; i++) applyStimulus(f[i], 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        mStats    = '0;
        mExpSeq   = 32'd0;
        mChecking = 1'b0;
        checkOutput("midreset_ready", 64'(ready), 64'd0);
        checkOutput("midreset_running", 64'(running), 64'd0);
        checkOutput("midreset_good_frames", 64'(goodFrames), 64'd0);
        checkOutput("midreset_good_bytes", goodBytes, 64'd0);
        repeat (2) @(negedge clk);
        checkOutput("midreset_ready_held", 64'(ready), 64'd0);
        rst = 1'b0;
        repeat (2) idleCycle();
        checkOutput("postreset_ready", 64'(ready), 64'd1);
        checkOutput("postreset_running", 64'(running), 64'd0);
        buildFrame(100, 32'd0, f); sendFrame(f, 1'b0, -1, -1, 0);
        repeat (4) idleCycle();

        checkOutput("pending_expected", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_checker.md
Name: frame_checker

Overview:
- Receive-side counterpart of the frame generator: an AXI-Stream slave that consumes test frames returning from the device under test.
- Byte-wise, it parses Ethernet/IPv4 headers and a payload sequence number, then classifies each frame as good or bad.
- Maintains per-port statistics (good/bad frames, good bytes, sequence errors) for the tester control logic.
- Sits between the port's RX AXIS path and the statistics readout.

Parameters:
- SEQ_OFFSET, 34, byte offset of the 32-bit big-endian sequence number; the generator emits it at the same offset.
- MIN_FRAME, 38, minimum legal frame length in bytes (SEQ_OFFSET+4).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: clear statistics, begin checking
- stop  in  1  one-cycle pulse: end checking after the current frame
- port_config  in  port_config_t  configuration of the sending port; uses frame_size, src_ip, dst_ip
- rx_mac  in  48  MAC of this receiving port; expected destination MAC
- axis_s_data  in  8  frame byte, wire order
- axis_s_valid  in  1  byte valid
- axis_s_last  in  1  last byte of frame; the frame excludes FCS
- axis_s_user  in  1  error flag, sampled on the last beat
- axis_s_ready  out  1  ready
- running  out  1  checking active
- good_frames  out  32  count of good frames
- bad_frames  out  32  count of bad frames
- good_bytes  out  64  sum of lengths of good frames
- seq_errors  out  32  count of good frames with an unexpected sequence number

Behaviour:
- Reset: all outputs 0 (axis_s_ready=0); state IDLE; expected_seq=0.
- axis_s_ready is 1 in every cycle after reset release; the block never back-pressures.
- A beat is transferred when valid&&ready.
- States:
  - IDLE: running=0. Transferred beats are discarded uncounted.
  - RX_HDR: running=1, at a frame boundary or inside a frame that is being checked.
  - SKIP: running=1, discarding a frame that started before start. Returns to RX_HDR after its last beat.
  - STOPPING: running=1, finishing the current checked frame. Goes to IDLE after its last beat.
- start:
  - Clears all counters and expected_seq in the next cycle.
  - If a frame is in progress (any beat transferred without last), go to SKIP; otherwise go to RX_HDR.
  - Valid from any state, including while running.
  - start and stop in the same cycle: start wins, stop ignored.
- stop:
  - In RX_HDR at a frame boundary: go to IDLE next cycle.
  - Mid-frame: go to STOPPING; that frame is still classified and counted.
  - In SKIP: go to IDLE after the last beat.
  - In IDLE: no effect.
- Byte counter: 16-bit, saturates at 0xFFFF, reset to 0 after each last beat. The beat at index n has offset n.
- Header checks, each latching a sticky mismatch flag for the frame:
  - offsets 0-5 == rx_mac, MSB byte first
  - 12-13 == 16'h0800
  - 14 == 8'h45
  - 26-29 == port_config.src_ip
  - 30-33 == port_config.dst_ip
  - SEQ_OFFSET..+3 captured as rx_seq
- Classification on the last beat. The frame is good iff all of:
  - length == port_config.frame_size
  - length >= MIN_FRAME
  - no mismatch flag set
  - axis_s_user==0
  - Otherwise it is bad.
- A single-beat frame (last at offset 0) is bad.
- Counter update timing: counters update in the cycle after the last-beat transfer; latency is 1 clock.
- Good frame: good_frames+=1, good_bytes+=length.
  - If rx_seq != expected_seq, seq_errors+=1.
  - expected_seq=rx_seq+1 (resynchronise; 32-bit wrap 0xFFFFFFFF->0).
- Bad frame: bad_frames+=1; expected_seq unchanged.
- Counter widths: 32-bit counters wrap; good_bytes does not overflow in practice and wraps.
- Back-to-back frames: a last beat followed immediately by the next frame's first beat must be handled with no bubble.
- port_config is sampled continuously and must be held stable while running.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

Decomposition:
- In tester_common package:
  - constants ETH_TYPE_IPV4=16'h0800, IPV4_VER_IHL=8'h45
  - offset localparams OFF_ETH_TYPE=12, OFF_VER_IHL=14, OFF_SRC_IP=26, OFF_DST_IP=30
  - frame_check_stats_t bundling the four counters
- port_config_t is reused unchanged.
- No sub-module: a single module containing parser, classifier and counters.

Test Plan:
- start, then one 100-byte frame with matching MAC/IPs, seq=0, frame_size=100 -> good_frames=1, good_bytes=100, bad_frames=0, seq_errors=0; counters change exactly 1 cycle after the last beat.
- Frame with dst_ip byte 33 corrupted -> bad_frames=1, good_frames=0, expected_seq still 0. Then a 99-byte frame -> bad_frames=2. Then a frame with user=1 on last -> bad_frames=3.
- Good frames with seq 0,1,3,4 sent back-to-back, valid held high -> good_frames=4, good_bytes=400, seq_errors=1.
- Frame begins, start pulses at offset 50 -> that frame not counted (SKIP); the following good frame seq=0 -> good_frames=1.
- stop pulses at offset 40 of a good frame -> good_frames=1, running falls the cycle after the last beat; the next frame is not counted.
- Assert rst at offset 20 with counters non-zero -> all counters 0, running=0, axis_s_ready=0 during reset.
